// File: rtl/car_motion_controller.sv
// -----------------------------------------------------------------------------
// car_motion_controller
//
// Purpose: moves the player car horizontally once per video frame from the
// debounced steering buttons, clamping it to the road lane. A crash pulse
// starts a timed sequence in which the car freezes and blinks, after which it
// respawns at X_INIT. Every output is registered, so the sprite renderer sees
// one stable position for the whole frame.
//
// Ports:
//   clk             system clock
//   reset           asynchronous, active-high reset
//   frame_tick      single-cycle pulse at the start of each frame
//   enable          level; low pauses the block, and ticks and crashes are dropped
//   btn_left        debounced level, request move left
//   btn_right       debounced level, request move right
//   crash           single-cycle pulse from the collision logic
//   car_position_x  road-relative x (8 bits)
//   car_position_y  screen y, constant Y_POS (10 bits)
//   car_visible     sprite enable
//   crashed         high while the crash sequence runs
//
// State table:
//   state    | meaning
//   ST_RUN   | normal driving; x follows the buttons on each frame tick
//   ST_CRASH | car frozen and blinking; counts frame ticks up to CRASH_FRAMES
// -----------------------------------------------------------------------------
module car_motion_controller #(
   parameter int STEP         = 2,
   parameter int X_INIT       = 112,
   parameter int X_MAX        = 239,
   parameter int Y_POS        = 416,
   parameter int CRASH_FRAMES = 60,
   parameter int BLINK_PERIOD = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       enable,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       crash,
   output logic [7:0] car_position_x,
   output logic [9:0] car_position_y,
   output logic       car_visible,
   output logic       crashed
);

   localparam int CW = $clog2(CRASH_FRAMES + 1);
   localparam int BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

   localparam logic [7:0]    X_INIT_C  = 8'(X_INIT);
   localparam logic [7:0]    X_MAX_C   = 8'(X_MAX);
   localparam logic [8:0]    X_MAX9_C  = 9'(X_MAX);
   localparam logic [7:0]    STEP_C    = 8'(STEP);
   localparam logic [8:0]    STEP9_C   = 9'(STEP);
   localparam logic [9:0]    Y_POS_C   = 10'(Y_POS);
   localparam logic [CW-1:0] CF_C      = CW'(CRASH_FRAMES);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [BW-1:0] BLINK_RLD = BW'(BLINK_PERIOD - 1);
   localparam logic [BW-1:0] BLINK_ONE = BW'(1);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_CRASH = 1'b1
   } state_t;

   state_t        state;
   logic [CW-1:0] frame_cnt;
   // Blink phase is tracked with a down-counter instead of a modulo on
   // frame_cnt: it is reloaded on crash entry, so it hits zero on every
   // BLINK_PERIOD-th tick after entry.
   logic [BW-1:0] blink_cnt;

   logic [8:0]    x_ext;
   logic [8:0]    x_add;
   logic [7:0]    x_left_sat;
   logic [7:0]    x_right_sat;
   logic [CW-1:0] cnt_next;

   // Saturating moves; the 9-bit sum keeps the carry visible so the clamp
   // at X_MAX cannot be defeated by an 8-bit wrap.
   always_comb begin
      x_ext       = {1'b0, car_position_x};
      x_add       = x_ext + STEP9_C;
      x_left_sat  = (x_ext < STEP9_C) ? 8'd0 : (car_position_x - STEP_C);
      x_right_sat = (x_add > X_MAX9_C) ? X_MAX_C : x_add[7:0];
      cnt_next    = frame_cnt + CNT_ONE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_RUN;
         car_position_x <= X_INIT_C;
         car_position_y <= Y_POS_C;
         car_visible    <= 1'b1;
         crashed        <= 1'b0;
         frame_cnt      <= '0;
         blink_cnt      <= BLINK_RLD;
      end else if (enable) begin
         case (state)
            ST_RUN: begin
               // A crash in the same cycle as a tick wins; the move is dropped.
               if (crash) begin
                  state       <= ST_CRASH;
                  crashed     <= 1'b1;
                  car_visible <= 1'b0;
                  frame_cnt   <= '0;
                  blink_cnt   <= BLINK_RLD;
               end else if (frame_tick) begin
                  case ({btn_left, btn_right})
                     2'b10:   car_position_x <= x_left_sat;
                     2'b01:   car_position_x <= x_right_sat;
                     default: car_position_x <= car_position_x;
                  endcase
               end
            end
            ST_CRASH: begin
               if (frame_tick) begin
                  if (cnt_next == CF_C) begin
                     // Respawn takes priority over a coincident blink toggle.
                     state          <= ST_RUN;
                     car_position_x <= X_INIT_C;
                     car_visible    <= 1'b1;
                     crashed        <= 1'b0;
                     frame_cnt      <= '0;
                     blink_cnt      <= BLINK_RLD;
                  end else begin
                     frame_cnt <= cnt_next;
                     if (blink_cnt == '0) begin
                        car_visible <= ~car_visible;
                        blink_cnt   <= BLINK_RLD;
                     end else begin
                        blink_cnt <= blink_cnt - BLINK_ONE;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule
